// File: rtl/gpu_fetch_pkg.sv
// Shared types and constants for the warp fetch scheduler and its arbiter.
package gpu_fetch_pkg;

  localparam int NUM_WARPS_DEF = 8;
  localparam int WID_W         = $clog2(NUM_WARPS_DEF);
  localparam int PC_INC        = 4;

  typedef enum logic {
    WS_IDLE   = 1'b0,
    WS_ACTIVE = 1'b1
  } warp_state_e;

  // Index width for n entries, never below one bit.
  function automatic int wid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_multi_grant_arbiter.sv
// Round-robin arbiter issuing up to NUM_GRANTS grants per cycle, scanning upward
// from a rotating pointer that moves just past the last granted requester.
module rr_multi_grant_arbiter
  import gpu_fetch_pkg::*;
#(
  parameter  int NUM_REQ    = 8,
  parameter  int NUM_GRANTS = 2,
  localparam int IW         = wid_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_i,
  output logic [NUM_GRANTS-1:0]    lane_vld_o,
  output logic [NUM_GRANTS*IW-1:0] lane_idx_o,
  output logic [NUM_REQ-1:0]       gnt_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;
  int            cnt;

  // Scan order is ptr, ptr+1, ... wrapping; NUM_REQ is a power of two so the
  // index simply truncates. Each requester is visited once, so no duplicates.
  always_comb begin
    lane_vld_o = '0;
    lane_idx_o = '0;
    gnt_o      = '0;
    ptr_d      = ptr_q;
    idx        = '0;
    cnt        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr_q + IW'(i);
      if (req_i[idx] && (cnt < NUM_GRANTS)) begin
        for (int g = 0; g < NUM_GRANTS; g++) begin
          if (cnt == g) begin
            lane_vld_o[g]            = 1'b1;
            lane_idx_o[g*IW +: IW]   = idx;
          end
        end
        gnt_o[idx] = 1'b1;
        ptr_d      = idx + IW'(1);
        cnt        = cnt + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/warp_fetch_scheduler.sv
// Per-warp launch/exit state and PC tracking, feeding a multi-lane round-robin
// fetch arbiter whose lane outputs are registered.
module warp_fetch_scheduler
  import gpu_fetch_pkg::*;
#(
  parameter  int NUM_WARPS  = 8,
  parameter  int NUM_GRANTS = 2,
  parameter  int PC_W       = 32,
  localparam int WW         = wid_w(NUM_WARPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_valid,
  input  logic [WW-1:0]              start_warp,
  input  logic [PC_W-1:0]            start_pc,
  input  logic [NUM_WARPS-1:0]       req,
  input  logic [NUM_WARPS-1:0]       stall,
  input  logic [NUM_WARPS-1:0]       redirect_valid,
  input  logic [NUM_WARPS*PC_W-1:0]  redirect_pc,
  input  logic [NUM_WARPS-1:0]       exit_valid,
  output logic [NUM_GRANTS-1:0]      fetch_valid,
  output logic [NUM_GRANTS*WW-1:0]   fetch_warp,
  output logic [NUM_GRANTS*PC_W-1:0] fetch_pc,
  output logic [NUM_WARPS-1:0]       squash,
  output logic [NUM_WARPS-1:0]       active
);

  warp_state_e               state_q [NUM_WARPS];
  warp_state_e               state_d [NUM_WARPS];
  logic [PC_W-1:0]           pc_q    [NUM_WARPS];
  logic [PC_W-1:0]           pc_d    [NUM_WARPS];
  logic [NUM_WARPS-1:0]      start_hit;
  logic [NUM_WARPS-1:0]      elig;
  logic [NUM_WARPS-1:0]      gnt;
  logic [NUM_GRANTS-1:0]     lane_vld;
  logic [NUM_GRANTS*WW-1:0]  lane_idx;

  logic [NUM_GRANTS-1:0]      fetch_valid_q;
  logic [NUM_GRANTS*WW-1:0]   fetch_warp_q;
  logic [NUM_GRANTS*PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [NUM_WARPS-1:0]       squash_q;

  // A warp being started, redirected or exited this cycle has a PC about to
  // change, so it sits out arbitration for the cycle.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      start_hit[w] = start_valid && (start_warp == WW'(w));
      elig[w]      = (state_q[w] == WS_ACTIVE) && req[w] && !stall[w] &&
                     !redirect_valid[w] && !exit_valid[w] && !start_hit[w];
    end
  end

  rr_multi_grant_arbiter #(
    .NUM_REQ    (NUM_WARPS),
    .NUM_GRANTS (NUM_GRANTS)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (elig),
    .lane_vld_o (lane_vld),
    .lane_idx_o (lane_idx),
    .gnt_o      (gnt)
  );

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      state_d[w] = state_q[w];
      pc_d[w]    = pc_q[w];
      if (start_hit[w]) begin
        pc_d[w] = start_pc;
      end else if (redirect_valid[w]) begin
        pc_d[w] = redirect_pc[w*PC_W +: PC_W];
      end else if (gnt[w]) begin
        pc_d[w] = pc_q[w] + PC_W'(PC_INC);
      end
      if (start_hit[w]) begin
        state_d[w] = WS_ACTIVE;
      end else if (exit_valid[w]) begin
        state_d[w] = WS_IDLE;
      end
    end
  end

  // Lanes carry the PC held before the grant edge increments it.
  always_comb begin
    fetch_pc_d = '0;
    for (int g = 0; g < NUM_GRANTS; g++) begin
      if (lane_vld[g]) begin
        fetch_pc_d[g*PC_W +: PC_W] = pc_q[lane_idx[g*WW +: WW]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= WS_IDLE;
        pc_q[w]    <= '0;
      end
      fetch_valid_q <= '0;
      fetch_warp_q  <= '0;
      fetch_pc_q    <= '0;
      squash_q      <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= state_d[w];
        pc_q[w]    <= pc_d[w];
      end
      fetch_valid_q <= lane_vld;
      fetch_warp_q  <= lane_idx;
      fetch_pc_q    <= fetch_pc_d;
      squash_q      <= redirect_valid | exit_valid;
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      active[w] = (state_q[w] == WS_ACTIVE);
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_warp  = fetch_warp_q;
  assign fetch_pc    = fetch_pc_q;
  assign squash      = squash_q;

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Directed and randomized bench for warp_fetch_scheduler against a warp-list model.
module tb_warp_fetch_scheduler;

  localparam int NW = 8;
  localparam int NG = 2;
  localparam int PW = 32;
  localparam int WW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_valid;
  logic [WW-1:0]     start_warp;
  logic [PW-1:0]     start_pc;
  logic [NW-1:0]     req, stall, redirect_valid, exit_valid;
  logic [NW*PW-1:0]  redirect_pc;
  logic [NG-1:0]     fetch_valid;
  logic [NG*WW-1:0]  fetch_warp;
  logic [NG*PW-1:0]  fetch_pc;
  logic [NW-1:0]     squash, active;

  warp_fetch_scheduler #(.NUM_WARPS(NW), .NUM_GRANTS(NG), .PC_W(PW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_valid    (start_valid),
    .start_warp     (start_warp),
    .start_pc       (start_pc),
    .req            (req),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exit_valid     (exit_valid),
    .fetch_valid    (fetch_valid),
    .fetch_warp     (fetch_warp),
    .fetch_pc       (fetch_pc),
    .squash         (squash),
    .active         (active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: which warps are running, their PCs, and where the next scan starts.
  bit          m_act [NW];
  logic [31:0] m_pc  [NW];
  int          m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      m_act[w] = 1'b0;
      m_pc[w]  = '0;
    end
    m_ptr = 0;
  endtask

  task automatic clear_inputs();
    start_valid    = 1'b0;
    start_warp     = '0;
    start_pc       = '0;
    req            = '0;
    stall          = '0;
    redirect_valid = '0;
    redirect_pc    = '0;
    exit_valid     = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fv"}, 64'(fetch_valid), 64'h0);
    chk({tag, "_fw"}, 64'(fetch_warp), 64'h0);
    chk({tag, "_fp"}, 64'(fetch_pc), 64'h0);
    chk({tag, "_sq"}, 64'(squash), 64'h0);
    chk({tag, "_act"}, 64'(active), 64'h0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("rst");
    rst_n = 1'b1;
  endtask

  // One clock: predict from the model, advance, compare, then commit the model.
  task automatic cyc();
    logic [NG-1:0]    e_fv;
    logic [NG*WW-1:0] e_fw;
    logic [NG*PW-1:0] e_fp;
    logic [NW-1:0]    e_sq, e_act;
    logic [31:0]      n_pc [NW];
    bit               n_act [NW];
    bit               granted [NW];
    int cnt, last, w;
    bit starting, ok;
    e_fv = '0; e_fw = '0; e_fp = '0; cnt = 0; last = -1;
    for (int k = 0; k < NW; k++) granted[k] = 1'b0;
    for (int k = 0; k < NW; k++) begin
      w = (m_ptr + k) % NW;
      starting = start_valid && (int'(start_warp) == w);
      ok = m_act[w] && req[w] && !stall[w] && !redirect_valid[w] && !exit_valid[w] && !starting;
      if (ok && cnt < NG) begin
        e_fv[cnt] = 1'b1;
        e_fw[cnt*WW +: WW] = w[WW-1:0];
        e_fp[cnt*PW +: PW] = m_pc[w];
        granted[w] = 1'b1;
        last = w;
        cnt++;
      end
    end
    e_sq = redirect_valid | exit_valid;
    for (int k = 0; k < NW; k++) begin
      starting = start_valid && (int'(start_warp) == k);
      if (starting) n_pc[k] = start_pc;
      else if (redirect_valid[k]) n_pc[k] = redirect_pc[k*PW +: PW];
      else if (granted[k]) n_pc[k] = m_pc[k] + 32'd4;
      else n_pc[k] = m_pc[k];
      if (starting) n_act[k] = 1'b1;
      else if (exit_valid[k]) n_act[k] = 1'b0;
      else n_act[k] = m_act[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NW; k++) begin
      m_pc[k]  = n_pc[k];
      m_act[k] = n_act[k];
      e_act[k] = n_act[k];
    end
    if (last >= 0) m_ptr = (last + 1) % NW;
    chk("fetch_valid", 64'(fetch_valid), 64'(e_fv));
    chk("fetch_warp", 64'(fetch_warp), 64'(e_fw));
    chk("fetch_pc", 64'(fetch_pc), 64'(e_fp));
    chk("squash", 64'(squash), 64'(e_sq));
    chk("active", 64'(active), 64'(e_act));
  endtask

  initial begin
    logic [2*WW-1:0] pair;
    clear_inputs();
    rst_n = 1'b0;
    #2;
    do_reset();

    // Two warps launched, then fetched together twice.
    start_valid = 1'b1; start_warp = 3'd0; start_pc = 32'h100; cyc();
    start_warp = 3'd3; start_pc = 32'h200; cyc();
    start_valid = 1'b0; req = '1; cyc();
    chk("two_warp_w1", 64'(fetch_warp), 64'({3'd3, 3'd0}));
    chk("two_warp_pc1", 64'(fetch_pc), {32'h200, 32'h100});
    cyc();
    chk("two_warp_pc2", 64'(fetch_pc), {32'h204, 32'h104});

    // All eight warps: pairs rotate through in order and wrap.
    do_reset();
    for (int w = 0; w < NW; w++) begin
      start_valid = 1'b1; start_warp = WW'(w); start_pc = 32'(w * 32'h1000); cyc();
    end
    start_valid = 1'b0; req = '1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      pair = {WW'(((k % 4) * 2) + 1), WW'((k % 4) * 2)};
      chk("rr_pairs", 64'(fetch_warp), 64'(pair));
      chk("rr_valid", 64'(fetch_valid), 64'h3);
    end

    // Redirect of warp 5 while it would otherwise be granted.
    cyc();
    redirect_valid[5] = 1'b1; redirect_pc[5*PW +: PW] = 32'h400; cyc();
    chk("redir_lanes", 64'(fetch_warp), 64'({3'd6, 3'd4}));
    chk("redir_squash5", 64'(squash[5]), 64'h1);
    redirect_valid = '0; req = 8'b0010_0000; cyc();
    chk("redir_warp", 64'(fetch_warp[WW-1:0]), 64'h5);
    chk("redir_pc", 64'(fetch_pc[PW-1:0]), 64'h400);

    // Exit and relaunch of warp 2 in the same cycle: relaunch wins.
    req = '0; exit_valid[2] = 1'b1;
    start_valid = 1'b1; start_warp = 3'd2; start_pc = 32'h800; cyc();
    chk("exit_start_act2", 64'(active[2]), 64'h1);
    exit_valid = '0; start_valid = 1'b0; req = 8'b0000_0100; cyc();
    chk("exit_start_pc", 64'(fetch_pc[PW-1:0]), 64'h800);
    exit_valid[1] = 1'b1; req = '0; cyc();
    chk("exit_act1", 64'(active[1]), 64'h0);
    exit_valid = '0;

    // PC wrap at the top of the address space.
    start_valid = 1'b1; start_warp = 3'd6; start_pc = 32'hFFFF_FFFC; cyc();
    start_valid = 1'b0; req = 8'b0100_0000; cyc();
    chk("wrap_pc0", 64'(fetch_pc[PW-1:0]), 64'hFFFF_FFFC);
    cyc();
    chk("wrap_pc1", 64'(fetch_pc[PW-1:0]), 64'h0);

    // Asynchronous reset in mid-stream, then no fetch on the first cycle back.
    req = '1; redirect_valid[0] = 1'b1; cyc();
    redirect_valid = '0; cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    chk("post_rst_fv", 64'(fetch_valid), 64'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      start_valid = ($urandom_range(0, 3) == 0);
      start_warp  = WW'($urandom_range(0, NW - 1));
      start_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      req         = NW'($urandom());
      stall       = NW'($urandom()) & NW'($urandom()) & NW'($urandom());
      redirect_valid = NW'($urandom()) & NW'($urandom()) & NW'($urandom()) & NW'($urandom());
      exit_valid  = NW'($urandom()) & NW'($urandom()) & NW'($urandom()) & NW'($urandom());
      for (int w = 0; w < NW; w++) redirect_pc[w*PW +: PW] = $urandom() & 32'hFFFF_FFFC;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/warp_fetch_scheduler.md
WARP_FETCH_SCHEDULER -- requirements
Module: warp_fetch_scheduler

Interface
REQ-001 Parameter NUM_WARPS, 8, number of warps (power of two, 2..32).
REQ-002 Parameter NUM_GRANTS, 2, fetch lanes per cycle (1..NUM_WARPS).
REQ-003 Parameter PC_W, 32, program-counter width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start_valid  in  1  TM launches warp start_warp.
REQ-007 start_warp  in  WID_W  warp index to launch.
REQ-008 start_pc  in  PC_W  launch PC.
REQ-009 req  in  NUM_WARPS  per-warp IB has a free slot.
REQ-010 stall  in  NUM_WARPS  per-warp SIMT stall.
REQ-011 redirect_valid  in  NUM_WARPS  per-warp branch/SIMT redirect.
REQ-012 redirect_pc  in  NUM_WARPS*PC_W  flattened targets; warp w at [w*PC_W +: PC_W].
REQ-013 exit_valid  in  NUM_WARPS  per-warp decoded EXIT.
REQ-014 fetch_valid  out  NUM_GRANTS  lane carries a fetch.
REQ-015 fetch_warp  out  NUM_GRANTS*WID_W  flattened warp index per lane.
REQ-016 fetch_pc  out  NUM_GRANTS*PC_W  flattened fetch PC per lane.
REQ-017 squash  out  NUM_WARPS  kill in-flight IF/ID entries of warp.
REQ-018 active  out  NUM_WARPS  warp launched and not exited.

Function
REQ-019 Per-warp state SHALL be IDLE or ACTIVE plus a PC_W-bit PC register.
REQ-020 Warp w SHALL be eligible when active[w] & req[w] & ~stall[w] & ~redirect_valid[w] & ~exit_valid[w] & ~(start_valid & start_warp==w).
REQ-021 Arbiter SHALL grant up to NUM_GRANTS eligible warps, scanning upward from rotating pointer ptr with wrap-around.
REQ-022 Lane 0 SHALL hold first granted warp in scan order, lane 1 the second, etc.; unused lanes valid=0, warp=0, pc=0.
REQ-023 After any grant ptr SHALL become (last granted index + 1) mod NUM_WARPS; no grant leaves ptr unchanged.
REQ-024 fetch_* SHALL be registered: grants evaluated in cycle t appear at t+1, carrying the PC held at t.
REQ-025 Granted warp PC SHALL advance by 4 at the grant edge, modulo 2^PC_W (0xFFFFFFFC -> 0x0 at PC_W=32).
REQ-026 PC update priority per warp: start (same warp) > redirect > grant increment > hold.
REQ-027 start_valid SHALL set warp ACTIVE and load start_pc next edge, even if already ACTIVE.
REQ-028 exit_valid SHALL set warp IDLE next edge, PC retained; start_valid to same warp same cycle wins (ACTIVE).
REQ-029 redirect_valid on IDLE warp SHALL load PC but leave state IDLE.
REQ-030 squash[w] SHALL be a registered one-cycle pulse at t+1 for redirect_valid[w] or exit_valid[w] at t.
REQ-031 Warp never appears in two lanes of one cycle.

Reset
REQ-032 On rst_n low, all outputs, ptr, state (IDLE) and PCs (0) SHALL clear asynchronously; deassertion synchronous to clk.
REQ-033 Reset mid-operation SHALL discard all pending grants; no fetch_valid in first cycle after release.

Structure
REQ-034 Package gpu_fetch_pkg SHALL hold WID_W=$clog2(NUM_WARPS), PC_INC=4, warp-state enum.
REQ-035 Sub-module rr_multi_grant_arbiter (NUM_REQ, NUM_GRANTS) SHALL implement REQ-021..023 and REQ-031.

Verification
REQ-036 Start warps 0,3 at 0x100,0x200, req all ones -> lanes {0@0x100, 3@0x200}, then {0@0x104, 3@0x204}.
REQ-037 All 8 active, req all ones, NUM_GRANTS=2 -> pairs (0,1),(2,3),(4,5),(6,7),(0,1) on consecutive cycles.
REQ-038 Warp 5 redirect to 0x400 while eligible -> no warp-5 fetch next cycle, squash[5]=1, following fetch pc 0x400.
REQ-039 exit_valid[2] with start_valid warp 2 same cycle -> active[2]=1, PC=start_pc.
REQ-040 PC 0xFFFFFFFC granted -> fetch_pc 0xFFFFFFFC, next 0x0; rst_n low mid-stream -> all outputs 0 same cycle.
